t_clkq_setup_sequencer: RTL and testbench

Control and post-processing stage that sits directly upstream and downstream of the t_clkq+t_setup measurement core. It drives the core's start pulse and waits a fixed measurement window. It then snapshots the core's measured_cnt and computes the wrap-safe count delta. It averages 2^LOG_AVG runs and reports the mean delta plus the max−min spread over a valid/ready handshake to the PVT monitor readout logic.

---
 rtl/t_clkq_setup_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_t_clkq_setup_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_clkq_setup_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// t_clkq_setup_sequencer: sequences start/window/capture runs of the clk-to-q +
// setup measurement core, and reports the averaged count delta and its spread. Rev 1.0
// ----------------------------------------------------------------------------
module t_clkq_setup_sequencer #(
  parameter int CNT_WIDTH = 8,
  parameter int WINDOW    = 200,
  parameter int START_LEN = 2,
  parameter int LOG_AVG   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 meas_req,
  output logic                 meas_start,
  input  logic [CNT_WIDTH-1:0] measured_cnt,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] result,
  output logic [CNT_WIDTH-1:0] spread,
  output logic                 result_valid,
  input  logic                 result_ready
);

  localparam int ACC_WIDTH = CNT_WIDTH + LOG_AVG;
  localparam int RUN_W     = (LOG_AVG > 0) ? LOG_AVG : 1;
  localparam int SC_W      = (START_LEN > 1) ? $clog2(START_LEN) : 1;

  localparam logic [SC_W-1:0]      START_LAST = SC_W'(START_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] WIN_LOAD   = CNT_WIDTH'(WINDOW - 1);
  localparam logic [RUN_W-1:0]     LAST_RUN   = RUN_W'((1 << LOG_AVG) - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  generate
    if (WINDOW < 1 || WINDOW > (2 ** CNT_WIDTH) - 2) begin : g_bad_window
      $error("t_clkq_setup_sequencer: WINDOW out of range 1..2^CNT_WIDTH-2");
    end
    if (START_LEN < 1) begin : g_bad_start_len
      $error("t_clkq_setup_sequencer: START_LEN must be >= 1");
    end
  endgenerate

  logic [2:0]           state_q, state_d;
  logic [SC_W-1:0]      start_cnt_q, start_cnt_d;
  logic [CNT_WIDTH-1:0] win_q, win_d;
  logic [RUN_W-1:0]     run_idx_q, run_idx_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] min_q, min_d;
  logic [CNT_WIDTH-1:0] max_q, max_d;
  logic [CNT_WIDTH-1:0] base_q, base_d;
  logic [CNT_WIDTH-1:0] result_q, result_d;
  logic [CNT_WIDTH-1:0] spread_q, spread_d;
  logic                 result_valid_q, result_valid_d;
  logic                 meas_start_q, meas_start_d;
  logic                 busy_q, busy_d;

  logic                 req_accept;
  logic [CNT_WIDTH-1:0] delta;
  logic [ACC_WIDTH-1:0] acc_avg;
  logic                 unused_acc;

  // A pending result blocks new requests unless it is being consumed this cycle.
  assign req_accept = meas_req && (!result_valid_q || result_ready);
  // Modular subtraction keeps the delta correct across a counter wrap.
  assign delta      = measured_cnt - base_q;
  assign acc_avg    = acc_q >> LOG_AVG;
  assign unused_acc = ^acc_avg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      start_cnt_q    <= '0;
      win_q          <= '0;
      run_idx_q      <= '0;
      acc_q          <= '0;
      min_q          <= '1;
      max_q          <= '0;
      base_q         <= '0;
      result_q       <= '0;
      spread_q       <= '0;
      result_valid_q <= 1'b0;
      meas_start_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_cnt_q    <= start_cnt_d;
      win_q          <= win_d;
      run_idx_q      <= run_idx_d;
      acc_q          <= acc_d;
      min_q          <= min_d;
      max_q          <= max_d;
      base_q         <= base_d;
      result_q       <= result_d;
      spread_q       <= spread_d;
      result_valid_q <= result_valid_d;
      meas_start_q   <= meas_start_d;
      busy_q         <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (req_accept) state_d = S_START;
      S_START:   if (start_cnt_q == '0) state_d = S_RUN;
      S_RUN:     if (win_q == '0) state_d = S_CAPTURE;
      S_CAPTURE: state_d = (run_idx_q == LAST_RUN) ? S_DONE : S_START;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_cnt_d    = start_cnt_q;
    win_d          = win_q;
    run_idx_d      = run_idx_q;
    acc_d          = acc_q;
    min_d          = min_q;
    max_d          = max_q;
    base_d         = base_q;
    result_d       = result_q;
    spread_d       = spread_q;
    result_valid_d = result_valid_q;

    if (result_valid_q && result_ready) result_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_accept) begin
          acc_d       = '0;
          run_idx_d   = '0;
          min_d       = '1;
          max_d       = '0;
          start_cnt_d = START_LAST;
        end
      end
      S_START: begin
        if (start_cnt_q == '0) begin
          base_d = measured_cnt;
          win_d  = WIN_LOAD;
        end else begin
          start_cnt_d = start_cnt_q - SC_W'(1);
        end
      end
      S_RUN: begin
        if (win_q != '0) win_d = win_q - CNT_WIDTH'(1);
      end
      S_CAPTURE: begin
        acc_d = acc_q + ACC_WIDTH'(delta);
        if (delta < min_q) min_d = delta;
        if (delta > max_q) max_d = delta;
        if (run_idx_q != LAST_RUN) begin
          run_idx_d   = run_idx_q + RUN_W'(1);
          start_cnt_d = START_LAST;
        end
      end
      S_DONE: begin
        result_d       = acc_avg[CNT_WIDTH-1:0];
        spread_d       = max_q - min_q;
        result_valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are registered copies of the next-state decode, so they track state_q exactly.
  always_comb begin
    meas_start_d = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
  end

  assign meas_start   = meas_start_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign spread       = spread_q;
  assign result_valid = result_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_t_clkq_setup_sequencer.sv
`default_nettype none
// Directed bench for t_clkq_setup_sequencer: free-running and modelled-delta
// measurement cores, wrap, averaging, backpressure, reset and busy requests.
module tb_t_clkq_setup_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       meas_req;
  logic       meas_start;
  logic [7:0] measured_cnt;
  logic       busy;
  logic [7:0] result;
  logic [7:0] spread;
  logic       result_valid;
  logic       result_ready;

  int checks = 0;
  int errors = 0;

  // Stimulus model of the measurement core.
  logic       mode_free;
  logic [7:0] free_cnt = 8'd0;
  logic [7:0] cnt_off;
  logic [7:0] dv [4];
  int         ms_rises = 0;
  logic       ms_prev = 1'b0;
  int         rise_base;
  int         idx;

  t_clkq_setup_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .meas_req     (meas_req),
    .meas_start   (meas_start),
    .measured_cnt (measured_cnt),
    .busy         (busy),
    .result       (result),
    .spread       (spread),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) free_cnt <= free_cnt + 8'd1;

  always @(negedge clk) begin
    if (meas_start && !ms_prev) ms_rises <= ms_rises + 1;
    ms_prev <= meas_start;
  end

  always_comb begin
    idx = ms_rises - rise_base - 1;
    if (idx < 0) idx = 0;
    if (idx > 3) idx = 3;
    if (mode_free) measured_cnt = free_cnt + cnt_off;
    else if (meas_start) measured_cnt = 8'd0;
    else measured_cnt = dv[idx];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < 2000) begin
      if (result_valid) ok = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic do_meas(output int cyc, output bit ok);
    rise_base = ms_rises;
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    wait_valid(cyc, ok);
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    meas_req = 1'b0;
    result_ready = 1'b1;
    mode_free = 1'b1;
    cnt_off = 8'd0;
    repeat (3) step();
    checks++;
    if ({meas_start, busy, result_valid, result, spread} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state: start=%b busy=%b valid=%b result=%0d spread=%0d, required all 0",
               meas_start, busy, result_valid, result, spread);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int rises [$];
    int vcyc = -1;
    int cyc = 0;
    logic prev = 1'b0;
    logic [7:0] r = 8'd0, s = 8'hff;
    logic b = 1'b1;
    int exp_rise [4] = '{1, 204, 407, 610};
    mode_free = 1'b1;
    result_ready = 1'b1;
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    cyc = 1;
    while (cyc <= 820) begin
      if (meas_start && !prev) rises.push_back(cyc);
      if (result_valid && vcyc < 0) begin
        vcyc = cyc; r = result; s = spread; b = busy;
      end
      prev = meas_start;
      step();
      cyc++;
    end
    checks++;
    if (rises.size() != 4) begin
      errors++;
      $display("FAIL basic_start_count: got %0d start pulses, required 4", rises.size());
    end
    for (int i = 0; i < 4 && i < rises.size(); i++) begin
      checks++;
      if (rises[i] != exp_rise[i]) begin
        errors++;
        $display("FAIL basic_start_cycle[%0d]: got %0d, required %0d", i, rises[i], exp_rise[i]);
      end
    end
    checks++;
    if (vcyc != 814) begin
      errors++;
      $display("FAIL basic_valid_cycle: got %0d, required 814", vcyc);
    end
    checks++;
    if (r !== 8'd201 || s !== 8'd0) begin
      errors++;
      $display("FAIL basic_result: result=%0d spread=%0d, required 201/0", r, s);
    end
    checks++;
    if (b !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_at_valid: got %b, required 0", b);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit ok;
    mode_free = 1'b1;
    result_ready = 1'b1;
    // Counter reads 248 now, so the last START cycle (cycle 2) samples base=250.
    cnt_off = 8'd248 - free_cnt;
    do_meas(cyc, ok);
    checks++;
    if (!ok || result !== 8'd201 || spread !== 8'd0) begin
      errors++;
      $display("FAIL wrap_result: ok=%b result=%0d spread=%0d, required 201/0", ok, result, spread);
    end
    step();
  endtask

  task automatic test_avg(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic [7:0] d3, input logic [7:0] exp_r, input logic [7:0] exp_s);
    int cyc;
    bit ok;
    mode_free = 1'b0;
    result_ready = 1'b1;
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    do_meas(cyc, ok);
    checks++;
    if (!ok || result !== exp_r || spread !== exp_s) begin
      errors++;
      $display("FAIL avg_result: ok=%b result=%0d spread=%0d, required %0d/%0d",
               ok, result, spread, exp_r, exp_s);
    end
    step();
    mode_free = 1'b1;
  endtask

  task automatic test_backpressure();
    int cyc;
    bit ok;
    bit bad = 1'b0;
    mode_free = 1'b1;
    result_ready = 1'b0;
    do_meas(cyc, ok);
    checks++;
    if (!ok || result !== 8'd201 || spread !== 8'd0) begin
      errors++;
      $display("FAIL bp_first_result: ok=%b result=%0d spread=%0d, required 201/0", ok, result, spread);
    end
    for (int i = 0; i < 50; i++) begin
      meas_req = (i % 7 == 3);
      step();
      if (!result_valid || result !== 8'd201 || spread !== 8'd0 || busy || meas_start) bad = 1'b1;
    end
    meas_req = 1'b0;
    step();
    checks++;
    if (bad || !result_valid || busy) begin
      errors++;
      $display("FAIL bp_hold: valid=%b busy=%b result=%0d glitch=%b, required 1/0/201/0",
               result_valid, busy, result, bad);
    end
    result_ready = 1'b1;
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    checks++;
    if (result_valid !== 1'b0 || meas_start !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b start=%b, required 0/1", result_valid, meas_start);
    end
    wait_valid(cyc, ok);
    checks++;
    if (!ok || result !== 8'd201) begin
      errors++;
      $display("FAIL bp_second_result: ok=%b result=%0d, required 201", ok, result);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    mode_free = 1'b1;
    result_ready = 1'b1;
    meas_req = 1'b1;
    step();
    meas_req = 1'b0;
    repeat (99) step();
    rst = 1'b1;
    step();
    checks++;
    if ({meas_start, busy, result_valid, result, spread} !== 19'd0) begin
      errors++;
      $display("FAIL reset_mid_run: start=%b busy=%b valid=%b result=%0d spread=%0d, required all 0",
               meas_start, busy, result_valid, result, spread);
    end
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (result_valid || meas_start || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_no_result: activity seen=%b after abort, required 0", seen);
    end
  endtask

  task automatic test_busy_req();
    int rises [$];
    int vcyc = -1;
    int cyc = 0;
    logic prev = 1'b0;
    bit ok;
    int wc;
    mode_free = 1'b1;
    result_ready = 1'b1;
    meas_req = 1'b1;
    step();
    cyc = 1;
    while (cyc <= 815) begin
      if (meas_start && !prev) rises.push_back(cyc);
      if (result_valid && vcyc < 0) vcyc = cyc;
      prev = meas_start;
      if (cyc < 815) step();
      cyc++;
    end
    meas_req = 1'b0;
    checks++;
    if (rises.size() != 5 || vcyc != 814) begin
      errors++;
      $display("FAIL busy_req_pulses: got %0d start pulses and valid at %0d, required 5 and 814",
               rises.size(), vcyc);
    end
    checks++;
    if (rises.size() != 5 || rises[4] != 815 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_req_restart: last pulse %0d valid=%b, required 815/0",
               (rises.size() > 0) ? rises[rises.size()-1] : -1, result_valid);
    end
    wait_valid(wc, ok);
    checks++;
    if (!ok || result !== 8'd201) begin
      errors++;
      $display("FAIL busy_req_second: ok=%b result=%0d, required 201", ok, result);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    meas_req = 1'b0;
    result_ready = 1'b1;
    mode_free = 1'b1;
    cnt_off = 8'd0;
    rise_base = 0;
    dv[0] = 8'd0; dv[1] = 8'd0; dv[2] = 8'd0; dv[3] = 8'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_avg(8'd198, 8'd200, 8'd202, 8'd204, 8'd201, 8'd6);
    test_avg(8'd3, 8'd3, 8'd3, 8'd4, 8'd3, 8'd1);
    test_backpressure();
    test_reset_mid_run();
    test_busy_req();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
